// File: rtl/stack_pkg.sv
// Shared defaults, opcode encodings and FSM state type for the two-requester stack arbiter.
package stack_pkg;
    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 16;
    localparam int PTR_W_DEF = 4;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, last-grant register advanced on adv.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt
);
    // 1 = requester 1 won last, so requester 0 has priority on the next tie
    logic last_q;

    always_ff @(posedge clk) begin
        if (rst)
            last_q <= 1'b1;
        else if (adv && (req != 2'b00))
            last_q <= gnt[1];
    end

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end
endmodule

// File: rtl/stack_arbiter.sv
// Shares one external stack memory between two requesters; IDLE/EXEC/DONE per operation.
module stack_arbiter
    import stack_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int PTR_W = PTR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic [1:0]       ack,
    output logic [1:0]       err,
    output logic [WIDTH-1:0] rdata,
    output logic             mem_we,
    output logic [PTR_W-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty,
    output logic             busy
);
    state_e             state_q, state_d;
    logic [1:0]         gnt, gnt_q;
    logic               op_q, err_q;
    logic [WIDTH-1:0]   wdata_q, rdata_q;
    logic [PTR_W:0]     count_q, count_m1;
    logic               sel_op, adv, exec_err;
    logic [WIDTH-1:0]   sel_wdata;

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign rdata    = rdata_q;
    assign busy     = (state_q != ST_IDLE);
    assign count_m1 = count_q - 1'b1;
    assign adv      = (state_q == ST_IDLE) && (req != 2'b00);
    assign sel_op    = gnt[1] ? op[1]  : op[0];
    assign sel_wdata = gnt[1] ? wdata1 : wdata0;
    // Overflow/underflow decided from the captured op and current occupancy
    assign exec_err = (op_q == OP_PUSH) ? full : empty;

    rr_arbiter2 u_rr (
        .clk (clk),
        .rst (rst),
        .req (req),
        .adv (adv),
        .gnt (gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            op_q    <= OP_POP;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (adv) begin
                gnt_q   <= gnt;
                op_q    <= sel_op;
                wdata_q <= sel_wdata;
            end
            if (state_q == ST_EXEC) begin
                err_q <= exec_err;
                if (!exec_err) begin
                    if (op_q == OP_PUSH) begin
                        count_q <= count_q + 1'b1;
                    end else begin
                        count_q <= count_m1;
                        rdata_q <= mem_rdata;
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req != 2'b00) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are suppressed while rst is high so an abandoned op never writes or acks
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = count_q[PTR_W-1:0];
        mem_wdata = wdata_q;
        ack       = 2'b00;
        err       = 2'b00;
        if (!rst) begin
            if (state_q == ST_EXEC && !exec_err) begin
                if (op_q == OP_PUSH)
                    mem_we = 1'b1;
                else
                    mem_addr = count_m1[PTR_W-1:0];
            end
            if (state_q == ST_DONE) begin
                ack = gnt_q;
                err = err_q ? gnt_q : 2'b00;
            end
        end
    end
endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a behavioural stack memory attached.
module tb_stack_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req, op, ack, err;
    logic [7:0] wdata0, wdata1, rdata, mem_wdata, mem_rdata;
    logic       mem_we, full, empty, busy;
    logic [3:0] mem_addr;
    logic [4:0] count;
    logic [7:0] mem [16];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    stack_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .op(op),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack(ack), .err(err), .rdata(rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .count(count), .full(full), .empty(empty), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 2'b00;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Called in IDLE with req already driven; walks EXEC, DONE and back to IDLE
    task automatic txn(input string tag, input logic [1:0] gnt, input logic we,
                       input logic chk_addr, input logic [3:0] addr, input logic [7:0] wd,
                       input logic e, input logic chk_rd, input logic [7:0] rd,
                       input logic [1:0] next_req, input logic [4:0] cnt);
        tick();
        chk({tag, ".exec_busy"}, busy, 1'b1);
        chk({tag, ".exec_ack"}, ack, 2'b00);
        chk({tag, ".exec_we"}, mem_we, we);
        if (chk_addr) chk({tag, ".exec_addr"}, mem_addr, addr);
        if (we) chk({tag, ".exec_wdata"}, mem_wdata, wd);
        tick();
        chk({tag, ".done_ack"}, ack, gnt);
        chk({tag, ".done_err"}, err, e ? gnt : 2'b00);
        chk({tag, ".done_we"}, mem_we, 1'b0);
        if (chk_rd) chk({tag, ".done_rdata"}, rdata, rd);
        req = next_req;
        tick();
        chk({tag, ".idle_ack"}, ack, 2'b00);
        chk({tag, ".count"}, count, cnt);
    endtask

    initial begin
        req = 2'b00; op = 2'b00; wdata0 = 8'h00; wdata1 = 8'h00;
        do_reset();
        chk("rst.count", count, 5'd0);
        chk("rst.empty", empty, 1'b1);
        chk("rst.full", full, 1'b0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.ack", ack, 2'b00);
        chk("rst.err", err, 2'b00);
        chk("rst.rdata", rdata, 8'h00);
        chk("rst.we", mem_we, 1'b0);

        // single push from requester 0
        op = 2'b01; wdata0 = 8'hA5; req = 2'b01;
        txn("push_a5", 2'b01, 1'b1, 1'b1, 4'd0, 8'hA5, 1'b0, 1'b0, 8'h00, 2'b00, 5'd1);

        // contention: both push, then both pop (LIFO order)
        do_reset();
        op = 2'b11; wdata0 = 8'h11; wdata1 = 8'h22; req = 2'b11;
        txn("dual_push0", 2'b01, 1'b1, 1'b1, 4'd0, 8'h11, 1'b0, 1'b0, 8'h00, 2'b10, 5'd1);
        txn("dual_push1", 2'b10, 1'b1, 1'b1, 4'd1, 8'h22, 1'b0, 1'b0, 8'h00, 2'b00, 5'd2);
        op = 2'b00; req = 2'b11;
        txn("dual_pop0", 2'b01, 1'b0, 1'b1, 4'd1, 8'h00, 1'b0, 1'b1, 8'h22, 2'b10, 5'd1);
        txn("dual_pop1", 2'b10, 1'b0, 1'b1, 4'd0, 8'h00, 1'b0, 1'b1, 8'h11, 2'b00, 5'd0);

        // underflow
        op = 2'b00; req = 2'b01;
        txn("pop_empty", 2'b01, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 8'h00, 2'b00, 5'd0);
        chk("pop_empty.rdata_hold", rdata, 8'h11);

        // fill to DEPTH, then overflow
        op = 2'b10;
        for (int i = 0; i < 16; i++) begin
            wdata1 = 8'(i * 3 + 1); req = 2'b10;
            txn("fill", 2'b10, 1'b1, 1'b1, 4'(i), 8'(i * 3 + 1), 1'b0, 1'b0, 8'h00, 2'b00, 5'(i + 1));
        end
        chk("fill.full", full, 1'b1);
        chk("fill.empty", empty, 1'b0);
        wdata1 = 8'hEE; req = 2'b10;
        txn("overflow", 2'b10, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 8'h00, 2'b00, 5'd16);
        op = 2'b00; req = 2'b10;
        txn("pop_top", 2'b10, 1'b0, 1'b1, 4'd15, 8'h00, 1'b0, 1'b1, 8'h2E, 2'b00, 5'd15);
        chk("pop_top.full", full, 1'b0);

        // both held continuously: strict alternation every 3 cycles
        do_reset();
        op = 2'b11; wdata0 = 8'h30; wdata1 = 8'h40; req = 2'b11;
        for (int i = 0; i < 6; i++) begin
            txn("rr_hold", (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1, 1'b1, 4'(i),
                (i % 2 == 0) ? 8'h30 : 8'h40, 1'b0, 1'b0, 8'h00,
                (i == 5) ? 2'b00 : 2'b11, 5'(i + 1));
        end

        // reset in EXEC of a push abandons it
        op = 2'b01; wdata0 = 8'h77; req = 2'b01;
        tick();
        chk("rst_exec.we_before", mem_we, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_exec.we_during", mem_we, 1'b0);
        chk("rst_exec.ack_during", ack, 2'b00);
        tick();
        rst = 1'b0; req = 2'b00;
        chk("rst_exec.busy", busy, 1'b0);
        chk("rst_exec.count", count, 5'd0);
        chk("rst_exec.ack", ack, 2'b00);
        tick();
        chk("rst_exec.no_ack", ack, 2'b00);
        chk("rst_exec.count2", count, 5'd0);

        // arbiter restarts with requester 0 preferred
        op = 2'b11; wdata0 = 8'h5A; wdata1 = 8'h6B; req = 2'b11;
        txn("rr_after_rst", 2'b01, 1'b1, 1'b1, 4'd0, 8'h5A, 1'b0, 1'b0, 8'h00, 2'b00, 5'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
